pluto_quad_encoder: RTL and testbench

//  Single-channel quadrature encoder counter. Feeds the SPI readback path of the stepper core.

---
 rtl/pluto_quad_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_pluto_quad_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pluto_quad_encoder.sv
// rtl/pluto_quad_encoder.sv - single-channel x4 quadrature encoder counter with index latch and SPI snapshot
//
// Purpose:
//   Synchronises and tick-filters the A/B/Z encoder pins, decodes x4 quadrature
//   into a wrapping CW-bit position count, optionally latches the count on the
//   rising edge of the filtered index, and presents a coherent snapshot taken
//   on each snap strobe for multi-byte SPI readout.
//
// Optional feature macro: QENC_INDEX_EN (Z filter, index latch, index_arm,
//   index_out, index_seen). Undefined: index outputs tie to 0 and enc_z /
//   index_arm are ignored.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous reset, active-high
//   tick        in   one-clk sample enable for the input filters
//   enc_a/b/z   in   asynchronous encoder pins
//   snap        in   one-clk snapshot strobe
//   index_arm   in   one-clk pulse: arm index latch, clear index_seen
//   count_out   out  snapshot of position count
//   index_out   out  snapshot of count latched at index
//   index_seen  out  snapshot: index latched since last arm
//   quad_err    out  snapshot of sticky illegal-transition flag

module pluto_quad_encoder #(
  parameter int CW   = 16,
  parameter int FILT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          enc_a,
  input  logic          enc_b,
  input  logic          enc_z,
  input  logic          snap,
  input  logic          index_arm,
  output logic [CW-1:0] count_out,
  output logic [CW-1:0] index_out,
  output logic          index_seen,
  output logic          quad_err
);

`ifdef QENC_INDEX_EN
  localparam int NP = 3;
`else
  localparam int NP = 2;
`endif

  localparam logic [3:0] FILT4 = 4'(FILT);

  // Pin vector: bit 0 = A, bit 1 = B, bit 2 = Z (index build only).
  logic [NP-1:0] pins;
`ifdef QENC_INDEX_EN
  assign pins = {enc_z, enc_b, enc_a};
`else
  assign pins = {enc_b, enc_a};
  logic unused_idx;
  assign unused_idx = enc_z ^ index_arm;
`endif

  // Synchroniser flops run through reset so the filtered values can be
  // preloaded from them, which is what keeps reset from producing a count.
  logic [NP-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    sync1_q <= pins;
    sync2_q <= sync1_q;
  end

  logic [NP-1:0]      filt_q, filt_d;
  logic [NP-1:0][3:0] fcnt_q, fcnt_d;
  logic [CW-1:0]      count_q, count_d;
  logic               err_int_q, err_int_d;
  logic [CW-1:0]      count_out_q, count_out_d;
  logic               quad_err_q, quad_err_d;
  logic [3:0]         ab_trans;
  logic               err_now;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    if (tick) begin
      for (int i = 0; i < NP; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (fcnt_q[i] + 4'd1 == FILT4) begin
            filt_d[i] = sync2_q[i];
            fcnt_d[i] = 4'd0;
          end else begin
            fcnt_d[i] = fcnt_q[i] + 4'd1;
          end
        end else begin
          fcnt_d[i] = 4'd0;
        end
      end
    end
  end

  // Decode on the filtered transition itself: {A,B} before vs after this clk.
  assign ab_trans = {filt_q[0], filt_q[1], filt_d[0], filt_d[1]};

  always_comb begin
    count_d = count_q;
    err_now = 1'b0;
    case (ab_trans)
      4'b0001, 4'b0111, 4'b1110, 4'b1000: count_d = count_q + CW'(1);
      4'b0100, 4'b1101, 4'b1011, 4'b0010: count_d = count_q - CW'(1);
      4'b0011, 4'b1100, 4'b0110, 4'b1001: err_now = 1'b1;
      default: ;
    endcase

    // Set beats the snap clear so an error in the snap clk is not lost.
    err_int_d = err_int_q;
    if (err_now) begin
      err_int_d = 1'b1;
    end else if (snap) begin
      err_int_d = 1'b0;
    end

    count_out_d = count_out_q;
    quad_err_d  = quad_err_q;
    if (snap) begin
      count_out_d = count_q;
      quad_err_d  = err_int_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q      <= sync2_q;
      fcnt_q      <= '0;
      count_q     <= '0;
      err_int_q   <= 1'b0;
      count_out_q <= '0;
      quad_err_q  <= 1'b0;
    end else begin
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      count_q     <= count_d;
      err_int_q   <= err_int_d;
      count_out_q <= count_out_d;
      quad_err_q  <= quad_err_d;
    end
  end

  assign count_out = count_out_q;
  assign quad_err  = quad_err_q;

`ifdef QENC_INDEX_EN
  logic          armed_q, armed_d;
  logic          seen_q, seen_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] index_out_q, index_out_d;
  logic          index_seen_q, index_seen_d;
  logic          z_rise;

  assign z_rise = filt_d[2] & ~filt_q[2];

  always_comb begin
    armed_d      = armed_q;
    seen_d       = seen_q;
    idx_d        = idx_q;
    index_out_d  = index_out_q;
    index_seen_d = index_seen_q;
    // Arming takes priority over a coincident Z edge.
    if (index_arm) begin
      armed_d = 1'b1;
      seen_d  = 1'b0;
    end else if (z_rise && armed_q) begin
      idx_d   = count_q;
      seen_d  = 1'b1;
      armed_d = 1'b0;
    end
    if (snap) begin
      index_out_d  = idx_q;
      index_seen_d = seen_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q      <= 1'b0;
      seen_q       <= 1'b0;
      idx_q        <= '0;
      index_out_q  <= '0;
      index_seen_q <= 1'b0;
    end else begin
      armed_q      <= armed_d;
      seen_q       <= seen_d;
      idx_q        <= idx_d;
      index_out_q  <= index_out_d;
      index_seen_q <= index_seen_d;
    end
  end

  assign index_out  = index_out_q;
  assign index_seen = index_seen_q;
`else
  assign index_out  = '0;
  assign index_seen = 1'b0;
`endif

endmodule

// File: tb/tb_pluto_quad_encoder.sv
// tb/tb_pluto_quad_encoder.sv - self-checking bench for pluto_quad_encoder

module tb_pluto_quad_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        enc_z = 1'b0;
  logic        snap = 1'b0;
  logic        index_arm = 1'b0;
  logic [15:0] count_out;
  logic [15:0] index_out;
  logic        index_seen;
  logic        quad_err;

  pluto_quad_encoder #(.CW(16), .FILT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_z      (enc_z),
    .snap       (snap),
    .index_arm  (index_arm),
    .count_out  (count_out),
    .index_out  (index_out),
    .index_seen (index_seen),
    .quad_err   (quad_err)
  );

  always #5 clk = ~clk;

  // Tick every fourth clock, changed on the falling edge.
  int tdiv = 0;
  always @(negedge clk) begin
    tdiv = tdiv + 1;
    tick = (tdiv % 4 == 0);
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position as an unbounded integer, phase as the index
  // along the gray cycle 00,01,11,10 (A is the MSB).
  int   pos   = 0;
  int   phase = 0;
  bit   err_exp = 0;
  int   idx_exp = 0;
  bit   seen_exp = 0;
  logic [15:0] exp16;

  task automatic drive_phase();
    case (phase & 3)
      0: begin enc_a = 1'b0; enc_b = 1'b0; end
      1: begin enc_a = 1'b0; enc_b = 1'b1; end
      2: begin enc_a = 1'b1; enc_b = 1'b1; end
      default: begin enc_a = 1'b1; enc_b = 1'b0; end
    endcase
  endtask

  // Ends on the falling edge right after the n-th tick edge.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      @(posedge clk);
      while (tick !== 1'b1 && guard < 20) begin
        @(posedge clk);
        guard++;
      end
      if (guard >= 20) begin
        n_cmp++; n_bad++;
        $display("FAIL tick_timeout: no tick within 20 clks");
      end
    end
    @(negedge clk);
  endtask

  task automatic do_snap();
    snap = 1'b1;
    @(posedge clk);
    @(negedge clk);
    snap = 1'b0;
  endtask

  task automatic step(input int dir, input int hold);
    phase = (phase + dir) & 3;
    pos   = pos + dir;
    drive_phase();
    wait_ticks(hold);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pos = 0; err_exp = 0; idx_exp = 0; seen_exp = 0;
  endtask

  task automatic check_count(input string name);
    exp16 = 16'(pos);
    n_cmp++;
    if (count_out !== exp16) begin
      n_bad++;
      $display("FAIL %s: count_out got %h expected %h", name, count_out, exp16);
    end
  endtask

  task automatic test_reset();
    phase = 0; drive_phase(); enc_z = 1'b0;
    apply_reset();
    n_cmp++;
    if ({count_out, index_out, index_seen, quad_err} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h/%h/%b/%b expected all 0",
               count_out, index_out, index_seen, quad_err);
    end
    wait_ticks(10);
    do_snap();
    check_count("reset_snap_count");
    n_cmp++;
    if (quad_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_snap_err: quad_err got %b expected 0", quad_err);
    end
  endtask

  task automatic test_forward_reverse();
    for (int i = 0; i < 4; i++) step(1, 4);
    do_snap();
    check_count("fwd4");
    for (int i = 0; i < 4; i++) step(-1, 4);
    do_snap();
    check_count("rev4");
  endtask

  task automatic test_wrap();
    step(-1, 4);
    do_snap();
    check_count("wrap_down");
    n_cmp++;
    if (count_out !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_down_abs: count_out got %h expected ffff", count_out);
    end
    step(1, 4);
    do_snap();
    check_count("wrap_up");
  endtask

  task automatic test_glitch();
    wait_ticks(1);
    enc_a = ~enc_a;
    wait_ticks(2);
    drive_phase();
    wait_ticks(4);
    do_snap();
    check_count("glitch_2ticks");

    // Move to phase 0 so the reverse step changes A only.
    while (phase != 0) step(1, 4);
    wait_ticks(1);
    phase = 3; drive_phase();
    wait_ticks(2);
    do_snap();
    check_count("a_after_2ticks");
    pos = pos - 1;
    wait_ticks(1);
    do_snap();
    check_count("a_after_3ticks");
  endtask

  task automatic test_quad_err();
    wait_ticks(1);
    phase = (phase + 2) & 3;
    drive_phase();
    err_exp = 1'b1;
    wait_ticks(4);
    do_snap();
    n_cmp++;
    if (quad_err !== err_exp) begin
      n_bad++;
      $display("FAIL qerr_set: quad_err got %b expected %b", quad_err, err_exp);
    end
    err_exp = 1'b0;
    check_count("qerr_count");
    do_snap();
    n_cmp++;
    if (quad_err !== err_exp) begin
      n_bad++;
      $display("FAIL qerr_clear: quad_err got %b expected %b", quad_err, err_exp);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int sel = int'($urandom_range(0, 9));
      if (sel < 7) begin
        step(($urandom_range(0, 1) == 0) ? -1 : 1, int'($urandom_range(4, 6)));
      end else begin
        wait_ticks(1);
        if ($urandom_range(0, 1) == 0) enc_a = ~enc_a; else enc_b = ~enc_b;
        wait_ticks(int'($urandom_range(1, 2)));
        drive_phase();
        wait_ticks(4);
      end
      if (it % 10 == 9) begin
        do_snap();
        check_count("random_walk");
        n_cmp++;
        if (quad_err !== 1'b0) begin
          n_bad++;
          $display("FAIL random_err: quad_err got %b expected 0", quad_err);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1, 5);
    do_snap();
    check_count("b2b_first");
    do_snap();
    check_count("b2b_second");
    // Outputs hold between snaps while the count moves on.
    exp16 = 16'(pos);
    step(1, 5);
    n_cmp++;
    if (count_out !== exp16) begin
      n_bad++;
      $display("FAIL hold_between_snaps: count_out got %h expected %h", count_out, exp16);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1, 4);
    snap = 1'b1;
    @(posedge clk);
    @(negedge clk);
    snap = 1'b0;
    apply_reset();
    do_snap();
    check_count("reset_mid");
  endtask

  task automatic test_index();
`ifdef QENC_INDEX_EN
    phase = 0; drive_phase(); enc_z = 1'b0;
    apply_reset();
    index_arm = 1'b1;
    @(negedge clk);
    index_arm = 1'b0;
    do_snap();
    n_cmp++;
    if (index_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL idx_armed_seen: index_seen got %b expected 0", index_seen);
    end
    for (int i = 0; i < 7; i++) step(1, 4);
    enc_z = 1'b1; idx_exp = pos; seen_exp = 1'b1;
    wait_ticks(5);
    enc_z = 1'b0;
    wait_ticks(5);
    for (int i = 0; i < 2; i++) step(1, 4);
    do_snap();
    exp16 = 16'(idx_exp);
    n_cmp++;
    if (index_out !== exp16 || index_out !== 16'd7) begin
      n_bad++;
      $display("FAIL idx_value: index_out got %h expected %h", index_out, exp16);
    end
    n_cmp++;
    if (index_seen !== seen_exp) begin
      n_bad++;
      $display("FAIL idx_seen: index_seen got %b expected %b", index_seen, seen_exp);
    end
    check_count("idx_count");
    enc_z = 1'b1;
    wait_ticks(5);
    enc_z = 1'b0;
    step(1, 4);
    do_snap();
    n_cmp++;
    if (index_out !== exp16) begin
      n_bad++;
      $display("FAIL idx_second_z: index_out got %h expected %h", index_out, exp16);
    end
`else
    enc_z = 1'b1;
    index_arm = 1'b1;
    @(negedge clk);
    index_arm = 1'b0;
    wait_ticks(5);
    enc_z = 1'b0;
    wait_ticks(5);
    do_snap();
    n_cmp++;
    if (index_out !== 16'd0 || index_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL idx_disabled: index_out %h index_seen %b expected 0/0", index_out, index_seen);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_forward_reverse();
    test_wrap();
    test_glitch();
    test_quad_err();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_index();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
